// File: rtl/control_fsm_if.sv
// Control bus between the multicycle sequencer and the PC/SP/memory block.
// The sequencer drives every strobe and select; the block returns the instruction word.
interface control_fsm_if;
    logic [15:0] Inst;
    logic        MemWrite;
    logic [1:0]  MemSrc;
    logic [2:0]  MemDst;
    logic [2:0]  PCSrc;
    logic [2:0]  SPSrc;
    logic        PCWrite;
    logic        SPWrite;
    logic        InstWrite;
    logic        jcmp;
    logic        PCReset;
    logic        SPReset;
    logic        RegWrite;
    logic        WbSel;

    modport master (
        input  Inst,
        output MemWrite, MemSrc, MemDst, PCSrc, SPSrc,
        output PCWrite, SPWrite, InstWrite, jcmp,
        output PCReset, SPReset, RegWrite, WbSel
    );

    modport slave (
        output Inst,
        input  MemWrite, MemSrc, MemDst, PCSrc, SPSrc,
        input  PCWrite, SPWrite, InstWrite, jcmp,
        input  PCReset, SPReset, RegWrite, WbSel
    );
endinterface

// File: rtl/control_fsm.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/writeback and
// counts retired instructions. Strobes are registered from the next state and opcode.
module control_fsm #(
    parameter logic [15:0] RESET_COUNT = 16'h0000
) (
    input  logic              clock,
    input  logic              reset,
    control_fsm_if.master     bus,
    output logic [2:0]        state,
    output logic              halted,
    output logic [15:0]       inst_count
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_ALU  = 4'd0;
    localparam logic [3:0] OP_LW   = 4'd1;
    localparam logic [3:0] OP_SW   = 4'd2;
    localparam logic [3:0] OP_PUSH = 4'd3;
    localparam logic [3:0] OP_POP  = 4'd4;
    localparam logic [3:0] OP_J    = 4'd5;
    localparam logic [3:0] OP_JR   = 4'd6;
    localparam logic [3:0] OP_JREL = 4'd7;
    localparam logic [3:0] OP_JCMP = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd9;

    typedef struct packed {
        logic       mem_write;
        logic [1:0] mem_src;
        logic [2:0] mem_dst;
        logic [2:0] pc_src;
        logic [2:0] sp_src;
        logic       pc_write;
        logic       sp_write;
        logic       inst_write;
        logic       jcmp;
        logic       pc_reset;
        logic       sp_reset;
        logic       reg_write;
        logic       wb_sel;
        logic       halted;
    } ctrl_t;

    // Moore decode of one state/opcode pair into the full strobe set.
    function automatic ctrl_t decode_ctrl(input state_t st, input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            ST_RESET: begin
                c.pc_reset = 1'b1;
                c.sp_reset = 1'b1;
            end
            ST_FETCH: begin
                c.mem_src    = 2'd0;
                c.inst_write = 1'b1;
                c.pc_write   = 1'b1;
                c.pc_src     = 3'd0;
            end
            ST_DECODE: c = '0;
            ST_EXEC: begin
                case (op)
                    OP_POP: begin
                        c.sp_write = 1'b1;
                        c.sp_src   = 3'd2;
                    end
                    OP_J: begin
                        c.pc_write = 1'b1;
                        c.pc_src   = 3'd2;
                    end
                    OP_JR: begin
                        c.pc_write = 1'b1;
                        c.pc_src   = 3'd3;
                    end
                    OP_JREL: begin
                        c.pc_write = 1'b1;
                        c.pc_src   = 3'd1;
                    end
                    OP_JCMP: begin
                        c.pc_write = 1'b1;
                        c.pc_src   = 3'd6;
                        c.jcmp     = 1'b1;
                    end
                    default: c = '0;
                endcase
            end
            ST_MEM: begin
                case (op)
                    OP_LW: c.mem_src = 2'd3;
                    OP_SW: begin
                        c.mem_src   = 2'd3;
                        c.mem_write = 1'b1;
                        c.mem_dst   = 3'd0;
                    end
                    // Write lands at the old sp while SP decrements on the same edge.
                    OP_PUSH: begin
                        c.mem_src   = 2'd1;
                        c.mem_write = 1'b1;
                        c.mem_dst   = 3'd0;
                        c.sp_write  = 1'b1;
                        c.sp_src    = 3'd1;
                    end
                    OP_POP: c.mem_src = 2'd1;
                    default: c = '0;
                endcase
            end
            ST_WB: begin
                c.reg_write = 1'b1;
                c.wb_sel    = (op == OP_LW) || (op == OP_POP);
            end
            ST_HALT: c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  opcode_r;
    logic [3:0]  opcode_next_s;
    logic        retire_s;
    logic [15:0] inst_count_r;
    ctrl_t       ctrl_r;
    logic        unused_inst_s;

    assign unused_inst_s = ^bus.Inst[11:0];

    // Next-state selection; the opcode is taken from Inst only while decoding.
    always_comb begin
        state_next_s  = ST_RESET;
        opcode_next_s = opcode_r;
        case (state_r)
            ST_RESET:  state_next_s = ST_FETCH;
            ST_FETCH:  state_next_s = ST_DECODE;
            ST_DECODE: begin
                opcode_next_s = bus.Inst[15:12];
                case (bus.Inst[15:12])
                    OP_ALU, OP_POP, OP_J, OP_JR, OP_JREL, OP_JCMP: state_next_s = ST_EXEC;
                    OP_LW, OP_SW, OP_PUSH:                         state_next_s = ST_MEM;
                    OP_HALT:                                       state_next_s = ST_HALT;
                    default:                                       state_next_s = ST_FETCH;
                endcase
            end
            ST_EXEC: begin
                case (opcode_r)
                    OP_ALU:  state_next_s = ST_WB;
                    OP_POP:  state_next_s = ST_MEM;
                    default: state_next_s = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                case (opcode_r)
                    OP_LW, OP_POP: state_next_s = ST_WB;
                    default:       state_next_s = ST_FETCH;
                endcase
            end
            ST_WB:   state_next_s = ST_FETCH;
            ST_HALT: state_next_s = ST_HALT;
            default: state_next_s = ST_RESET;
        endcase
    end

    // An instruction retires on every return to FETCH other than the one out of RESET.
    always_comb begin
        if ((state_next_s == ST_FETCH) && (state_r != ST_RESET)) begin
            retire_s = 1'b1;
        end else begin
            retire_s = 1'b0;
        end
    end

    // State and opcode latch.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= ST_RESET;
            opcode_r <= 4'd0;
        end else begin
            state_r  <= state_next_s;
            opcode_r <= opcode_next_s;
        end
    end

    // Strobe register, loaded with the decode of the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_r <= decode_ctrl(ST_RESET, 4'd0);
        end else begin
            ctrl_r <= decode_ctrl(state_next_s, opcode_next_s);
        end
    end

    // Retired-instruction counter, wraps at 16 bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            inst_count_r <= RESET_COUNT;
        end else if (retire_s) begin
            inst_count_r <= inst_count_r + 16'd1;
        end else begin
            inst_count_r <= inst_count_r;
        end
    end

    assign bus.MemWrite  = ctrl_r.mem_write;
    assign bus.MemSrc    = ctrl_r.mem_src;
    assign bus.MemDst    = ctrl_r.mem_dst;
    assign bus.PCSrc     = ctrl_r.pc_src;
    assign bus.SPSrc     = ctrl_r.sp_src;
    assign bus.PCWrite   = ctrl_r.pc_write;
    assign bus.SPWrite   = ctrl_r.sp_write;
    assign bus.InstWrite = ctrl_r.inst_write;
    assign bus.jcmp      = ctrl_r.jcmp;
    assign bus.PCReset   = ctrl_r.pc_reset;
    assign bus.SPReset   = ctrl_r.sp_reset;
    assign bus.RegWrite  = ctrl_r.reg_write;
    assign bus.WbSel     = ctrl_r.wb_sel;
    assign state         = state_r;
    assign halted        = ctrl_r.halted;
    assign inst_count    = inst_count_r;

    control_fsm_checker u_checker (
        .clock      (clock),
        .state      (state_r),
        .mem_write  (ctrl_r.mem_write),
        .inst_write (ctrl_r.inst_write),
        .pc_write   (ctrl_r.pc_write),
        .halted     (ctrl_r.halted)
    );

endmodule

// Safety properties of the strobe outputs, kept apart from the datapath logic.
module control_fsm_checker (
    input logic       clock,
    input logic [2:0] state,
    input logic       mem_write,
    input logic       inst_write,
    input logic       pc_write,
    input logic       halted
);
    a_mem_inst_exclusive: assert property (@(posedge clock) !(mem_write && inst_write))
        else $error("MemWrite and InstWrite asserted together");

    a_no_pc_write_late: assert property (@(posedge clock)
        !(pc_write && ((state == 3'd4) || (state == 3'd5))))
        else $error("PCWrite asserted in MEM or WB");

    a_halted_matches_state: assert property (@(posedge clock) (halted == (state == 3'd6)))
        else $error("halted disagrees with state");

    a_legal_state: assert property (@(posedge clock) (state != 3'd7))
        else $error("illegal state encoding");
endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: a table of instruction vectors plus hand-written
// reset/halt sequences; expected per-cycle outputs come from a spec-level reference.
module tb_control_fsm;
    localparam logic [15:0] RC = 16'hFFFE;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  state;
    logic        halted;
    logic [15:0] inst_count;

    always #5 clock = ~clock;

    control_fsm_if bus();

    control_fsm #(.RESET_COUNT(RC)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .state      (state),
        .halted     (halted),
        .inst_count (inst_count)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic        mw;
        logic [1:0]  msrc;
        logic [2:0]  mdst;
        logic [2:0]  pcsrc;
        logic [2:0]  spsrc;
        logic        pcw;
        logic        spw;
        logic        iw;
        logic        jc;
        logic        pcr;
        logic        spr;
        logic        rw;
        logic        wb;
        logic        hl;
        logic [15:0] cnt;
    } obs_t;

    typedef struct {
        string           name;
        logic [15:0]     inst;
        int              len;
        logic [4:0][2:0] seq;
    } vec_t;

    obs_t  sb_q[$];
    string tag_q[$];
    int    checks = 0;
    int    passed = 0;

    logic [2:0]  prev_st;
    logic        prev_rst;
    logic [15:0] exp_cnt;
    vec_t        vecs[11];

    function automatic vec_t mkv(input string n, input logic [15:0] i, input int l,
                                 input logic [2:0] s0, input logic [2:0] s1, input logic [2:0] s2,
                                 input logic [2:0] s3, input logic [2:0] s4);
        vec_t v;
        v.name = n; v.inst = i; v.len = l;
        v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2; v.seq[3] = s3; v.seq[4] = s4;
        return v;
    endfunction

    // Reference strobes taken directly from the per-state output table.
    function automatic obs_t expect_out(input logic [2:0] st, input logic [3:0] op, input logic [15:0] cnt);
        obs_t e;
        e = '0;
        e.st = st;
        e.cnt = cnt;
        case (st)
            3'd0: begin e.pcr = 1'b1; e.spr = 1'b1; end
            3'd1: begin e.iw = 1'b1; e.pcw = 1'b1; end
            3'd3: begin
                case (op)
                    4'd4: begin e.spw = 1'b1; e.spsrc = 3'd2; end
                    4'd5: begin e.pcw = 1'b1; e.pcsrc = 3'd2; end
                    4'd6: begin e.pcw = 1'b1; e.pcsrc = 3'd3; end
                    4'd7: begin e.pcw = 1'b1; e.pcsrc = 3'd1; end
                    4'd8: begin e.pcw = 1'b1; e.pcsrc = 3'd6; e.jc = 1'b1; end
                    default: ;
                endcase
            end
            3'd4: begin
                case (op)
                    4'd1: e.msrc = 2'd3;
                    4'd2: begin e.msrc = 2'd3; e.mw = 1'b1; end
                    4'd3: begin e.msrc = 2'd1; e.mw = 1'b1; e.spw = 1'b1; e.spsrc = 3'd1; end
                    4'd4: e.msrc = 2'd1;
                    default: ;
                endcase
            end
            3'd5: begin e.rw = 1'b1; e.wb = (op == 4'd1) || (op == 4'd4); end
            3'd6: e.hl = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    // One cycle: push the expectation for the current cycle, drive inputs for the next edge.
    task automatic step(input logic [2:0] st, input logic [3:0] op, input logic [15:0] inst_v,
                        input logic rst_v, input string tag);
        if (prev_rst) exp_cnt = RC;
        else if (st == 3'd1 && prev_st != 3'd0) exp_cnt = exp_cnt + 16'd1;
        sb_q.push_back(expect_out(st, op, exp_cnt));
        tag_q.push_back(tag);
        bus.Inst = (st == 3'd2) ? inst_v : 16'($urandom);
        reset    = rst_v;
        prev_st  = st;
        prev_rst = rst_v;
        @(posedge clock);
        #1;
    endtask

    // Monitor: compare DUT outputs against the oldest expectation, away from the edge.
    always @(negedge clock) begin
        obs_t  e;
        obs_t  a;
        string t;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            a.st = state;          a.mw = bus.MemWrite;   a.msrc = bus.MemSrc;
            a.mdst = bus.MemDst;   a.pcsrc = bus.PCSrc;   a.spsrc = bus.SPSrc;
            a.pcw = bus.PCWrite;   a.spw = bus.SPWrite;   a.iw = bus.InstWrite;
            a.jc = bus.jcmp;       a.pcr = bus.PCReset;   a.spr = bus.SPReset;
            a.rw = bus.RegWrite;   a.wb = bus.WbSel;      a.hl = halted;
            a.cnt = inst_count;
            checks++;
            if (a === e) passed++;
            else $display("FAIL %s: got %h expected %h (state %0d exp %0d, count %h exp %h)",
                          t, a, e, a.st, e.st, a.cnt, e.cnt);
        end
    end

    initial begin
        vecs[0]  = mkv("alu",  16'h0ABC, 4, 3'd1, 3'd2, 3'd3, 3'd5, 3'd0);
        vecs[1]  = mkv("lw",   16'h1234, 4, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0);
        vecs[2]  = mkv("sw",   16'h2000, 3, 3'd1, 3'd2, 3'd4, 3'd0, 3'd0);
        vecs[3]  = mkv("push", 16'h3000, 3, 3'd1, 3'd2, 3'd4, 3'd0, 3'd0);
        vecs[4]  = mkv("pop",  16'h4000, 5, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5);
        vecs[5]  = mkv("j",    16'h5000, 3, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0);
        vecs[6]  = mkv("jr",   16'h6123, 3, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0);
        vecs[7]  = mkv("jrel", 16'h7FFF, 3, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0);
        vecs[8]  = mkv("jcmp", 16'h8005, 3, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0);
        vecs[9]  = mkv("nopF", 16'hF000, 2, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0);
        vecs[10] = mkv("nopA", 16'hA5A5, 2, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0);

        reset    = 1'b1;
        bus.Inst = 16'h0000;
        prev_st  = 3'd0;
        prev_rst = 1'b1;
        exp_cnt  = RC;
        @(posedge clock);
        #1;

        // Reset held for three edges, then one RESET cycle after release.
        step(3'd0, 4'd0, 16'h0000, 1'b1, "reset_hold");
        step(3'd0, 4'd0, 16'h0000, 1'b1, "reset_hold");
        step(3'd0, 4'd0, 16'h0000, 1'b0, "reset_release");

        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].len; c++) begin
                step(vecs[i].seq[c], vecs[i].inst[15:12], vecs[i].inst, 1'b0, vecs[i].name);
            end
        end

        // Halt: HALT for 20 cycles with everything frozen, then reset recovers.
        step(3'd1, 4'd9, 16'h9000, 1'b0, "halt");
        step(3'd2, 4'd9, 16'h9000, 1'b0, "halt");
        for (int k = 0; k < 20; k++) step(3'd6, 4'd9, 16'h0000, 1'b0, "halted");
        step(3'd6, 4'd9, 16'h0000, 1'b1, "halted_reset");
        step(3'd0, 4'd0, 16'h0000, 1'b0, "halt_recover");

        // Reset during sw MEM: the write still happens, the instruction is not counted.
        step(3'd1, 4'd2, 16'h2000, 1'b0, "sw_abort");
        step(3'd2, 4'd2, 16'h2000, 1'b0, "sw_abort");
        step(3'd4, 4'd2, 16'h2000, 1'b1, "sw_abort_mem");
        step(3'd0, 4'd0, 16'h0000, 1'b0, "sw_abort_reset");

        for (int c = 0; c < vecs[0].len; c++) begin
            step(vecs[0].seq[c], vecs[0].inst[15:12], vecs[0].inst, 1'b0, "alu_after_abort");
        end
        step(3'd1, 4'd0, 16'h0000, 1'b0, "final_fetch");

        @(negedge clock);
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending expectations, required 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/control_fsm.md
# control_fsm

Multicycle control unit directly upstream of the PC/SP/memory block. It sequences every instruction through fetch, decode, execute, memory and writeback. It drives that block's MemWrite, MemSrc, MemDst, PCSrc, SPSrc, PCWrite, SPWrite, InstWrite, jcmp, PCReset and SPReset inputs, and it decodes the opcode of the Inst_out word that block returns. All outputs are Moore outputs, decoded from the state register plus the latched opcode.

## Interface
- RESET_COUNT, default 0: value loaded into inst_count on reset.
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Inst  in  16  instruction register value; opcode = Inst[15:12].
- MemWrite  out  1  memory write strobe.
- MemSrc  out  2  address select: 0 pc, 1 sp, 2 ze_imm, 3 ls_imm.
- MemDst  out  3  write-data select: 0 Mary, 1 Shelley, 2 RA.
- PCSrc  out  3  PC next select: 0 pc+2, 1 immPlusPC, 2 immAddr, 3 ra, 4 mary, 5 pcPlusMary, 6 jcmp target.
- SPSrc  out  3  SP next select: 0 hold, 1 sp-2, 2 sp+2.
- PCWrite, SPWrite, InstWrite  out  1 each  register write enables.
- jcmp  out  1  compare-jump qualifier.
- PCReset, SPReset  out  1 each  PC/SP reset strobes.
- RegWrite  out  1  register-file write enable.
- WbSel  out  1  writeback source: 0 ALU, 1 MemVal.
- state  out  3  current state, for debug.
- halted  out  1  high while in HALT.
- inst_count  out  16  count of retired instructions.

## Operation
- States: RESET=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Encodings 7 and up go to RESET.
- Every output not named for a state is 0 in that state.
- RESET: PCReset=1, SPReset=1. Next state FETCH.
- FETCH: MemSrc=0, InstWrite=1, PCWrite=1, PCSrc=0. Next state DECODE.
- DECODE: all outputs 0. The opcode is latched from Inst. Next state by opcode:
  - 0 (ALU): EXEC, then WB.
  - 1 (lw): MEM, then WB.
  - 2 (sw): MEM, then FETCH.
  - 3 (push): MEM, then FETCH.
  - 4 (pop): EXEC, then MEM, then WB.
  - 5 (j), 6 (jr), 7 (jrel), 8 (jcmp): EXEC, then FETCH.
  - 9 (halt): HALT.
  - 10–15: FETCH. These retire as NOPs.
- EXEC by opcode:
  - ALU: no strobes.
  - pop: SPWrite=1, SPSrc=2.
  - j: PCWrite=1, PCSrc=2.
  - jr: PCWrite=1, PCSrc=3.
  - jrel: PCWrite=1, PCSrc=1.
  - jcmp: PCWrite=1, PCSrc=6, jcmp=1.
- MEM by opcode:
  - lw: MemSrc=3.
  - sw: MemSrc=3, MemWrite=1, MemDst=0.
  - push: MemSrc=1, MemWrite=1, MemDst=0, SPWrite=1, SPSrc=1. The write lands at the old sp, and SP decrements on the same edge.
  - pop: MemSrc=1. The read uses the already-incremented sp.
- WB: RegWrite=1. WbSel=1 for lw and pop, 0 for ALU.
- HALT: halted=1, no strobes. Only reset exits HALT.
- inst_count increments by 1, wrapping at 16 bits, on every edge whose next state is FETCH, except the edge leaving RESET.

## Timing
- Reset is sampled on the rising edge. The edge with reset=1 forces state=RESET and inst_count=RESET_COUNT, and clears the opcode latch.
- While reset is held, PCReset=SPReset=1 and every other output is 0.
- During the cycle in which reset is first asserted, outputs still reflect the current state. A MemWrite in that cycle is permitted.
- Reset mid-instruction discards the instruction. It is not counted.
- After reset is deasserted: one RESET cycle, then FETCH.
- Cycles per instruction:
  - ALU 4 (F,D,E,WB).
  - lw 4 (F,D,M,WB).
  - sw 3.
  - push 3.
  - pop 5.
  - jumps 3.
  - NOP 2.
  - halt 2, then HALT indefinitely.
- MemVal is valid in WB, one cycle after MEM.
- Opcode decode uses Inst only in DECODE. Inst changes at any other time have no effect.
- Outputs change only on clock edges; there is no combinational path from Inst to outputs.
- Strobe exclusivity: MemWrite and InstWrite are never both 1, and PCWrite is never 1 in MEM or WB.

## Test plan
- Reset held 3 cycles, then released: state=0 with PCReset=SPReset=1 throughout and one cycle after release. Then FETCH with InstWrite=1, PCWrite=1, PCSrc=0. inst_count=0.
- Inst=0x1234 (lw) fetched: state sequence 1,2,4,5. MEM has MemSrc=3, MemWrite=0. WB has RegWrite=1, WbSel=1. inst_count increments on the WB→FETCH edge.
- Inst=0x3000 (push), then Inst=0x4000 (pop):
  - push: MEM has MemWrite=1, MemSrc=1, SPWrite=1, SPSrc=1.
  - pop: EXEC has SPWrite=1, SPSrc=2. MEM has MemSrc=1. WB has WbSel=1.
  - The pair takes 8 cycles in total.
- Inst=0x8005 (jcmp): EXEC has PCWrite=1, PCSrc=6, jcmp=1. Next state FETCH after 3 cycles. Inst=0xF000 retires in 2 cycles with no strobes outside FETCH.
- Inst=0x9000 (halt): state goes to 6 and halted=1, with all strobes 0 for 20 cycles and inst_count frozen. Reset then returns to RESET then FETCH.
- Reset asserted during sw MEM: MemWrite=1 in that cycle. The next cycle has state=0, MemWrite=0, and inst_count=RESET_COUNT.
